keccak_arbiter: RTL and testbench
=================================

# keccak_arbiter

Shares the single `keccak` sponge core between up to `N_REQ` Kyber requesters: matrix-A XOF (SHAKE128), PRF/CBD (SHAKE256), and hash H/G (SHA3-256/512). It arbitrates among pending requests and locks the core to one winner for a whole job. While locked, it latches that job's mode and lengths, forwards its input stream, and routes the output stream back to it. It releases the core after the last output word.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `BW_DATA`, 64: stream word width in bits; must match the core.
- `BW_IBLEN`, 16: input byte-length width.
- `BW_OBLEN`, 16: output byte-length width.

Ports:
- `i_clk` in 1: clock.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_req` in N_REQ: job request per requester; level, held until `o_done`.
- `i_req_mode` in 2*N_REQ: per-requester mode. 0=SHAKE128, 1=SHAKE256, 2=SHA3_256, 3=SHA3_512.
- `i_req_ibytes_len` in BW_IBLEN*N_REQ: per-requester input length in bytes.
- `i_req_obytes_len` in BW_OBLEN*N_REQ: per-requester output length in bytes; ignored for SHA3 modes.
- `i_req_ibytes` in BW_DATA*N_REQ: per-requester input word.
- `i_req_ibytes_valid` in N_REQ: per-requester input word valid.
- `o_req_ibytes_ready` out N_REQ: input ready, granted requester only.
- `o_req_obytes` out BW_DATA: output word, broadcast to all requesters.
- `o_req_obytes_valid` out N_REQ: output valid, granted requester only.
- `o_gnt` out N_REQ: one-hot grant.
- `o_done` out N_REQ: one-cycle job-complete pulse.
- `o_core_mode` out 2: mode to the core.
- `o_core_ibytes_len` out BW_IBLEN: input length to the core.
- `o_core_obytes_len` out BW_OBLEN: output length to the core.
- `o_core_ibytes` out BW_DATA: input word to the core.
- `o_core_ibytes_valid` out 1: input valid to the core.
- `i_core_ibytes_ready` in 1: input ready from the core.
- `i_core_obytes` in BW_DATA: output word from the core.
- `i_core_obytes_valid` in 1: output valid from the core.

## Operation
- FSM states: S_IDLE, S_BUSY, S_DONE.
- S_IDLE → S_BUSY when `|i_req`. On that edge:
  - the winner's mode and lengths are latched into `o_core_*`;
  - `o_gnt` is set one-hot;
  - the target word count is latched.
- Target word count:
  - SHAKE modes: W = ceil(obytes_len*8/BW_DATA), minimum 1.
  - SHA3_256: 32 bytes, giving W=4 at BW_DATA=64.
  - SHA3_512: 64 bytes, giving W=8 at BW_DATA=64.
- Winner selection is round-robin. The pointer starts at 0. The search begins at the pointer and takes the first set `i_req` bit. On grant, the pointer moves to winner+1 mod N_REQ.
- S_BUSY data path, all combinational muxes on the latched grant:
  - `o_core_ibytes` and `o_core_ibytes_valid` are taken from the winner;
  - `o_req_ibytes_ready[g] = i_core_ibytes_ready`;
  - `o_req_obytes = i_core_obytes`;
  - `o_req_obytes_valid[g] = i_core_obytes_valid`.
- All non-granted ready and valid bits are 0. `o_core_ibytes_valid` is 0 outside S_BUSY.
- Output counter: increments on each `i_core_obytes_valid` in S_BUSY. When a valid arrives with count == W-1, the FSM goes to S_DONE.
- S_DONE lasts one cycle:
  - `o_done[g]` = 1;
  - `o_gnt` clears on exit;
  - the counter clears;
  - next state is S_IDLE.
- Latched mode and lengths stay stable for the whole job, whatever the requester does to its own inputs.
- Deasserting `i_req` mid-job does not abort the job. The job runs to W words.
- `i_core_obytes_valid` in S_IDLE or S_DONE is dropped. It is not counted or routed.

## Timing
- Reset values:
  - `o_gnt` = 0, `o_done` = 0, `o_core_mode` = 0, both `o_core_*_len` = 0;
  - all valid and ready outputs = 0, `o_req_obytes` = 0;
  - pointer = 0, state = S_IDLE.
- Grant latency: `i_req` rises at cycle t in S_IDLE → `o_gnt` and `o_core_*` are valid at t+1. The first input word can be accepted at t+1.
- Release: last output word at cycle t → `o_done` = 1 at t+1 → S_IDLE at t+2. A still-pending request is granted at t+3. Turnaround is 2 idle cycles.
- A requester holding `i_req` after its `o_done` is re-arbitrated normally, behind the others under round-robin.
- Asynchronous reset mid-job returns everything to reset values immediately. The core must be reset by the same `i_rstn`.

## Configuration
- `KECCAK_ARB_PRIO0_EN`, defined: requester 0 wins whenever `i_req[0]` is set in S_IDLE, bypassing round-robin; the pointer is not updated on a requester-0 grant. Use for the latency-critical matrix-A XOF.
- Undefined: pure round-robin for all requesters.

## Test plan
- Single SHA3_512 job on requester 2, ibytes_len=32 (4 words) → gnt=4'b0100 one cycle after req, exactly 8 `o_req_obytes_valid[2]` pulses, then `o_done[2]` for one cycle, then gnt=0.
- Requesters 0, 1, 3 all assert together, each SHAKE128 with obytes_len=168 → grant order 0, 1, 3, each job gets 21 output words, and 2 idle cycles between a `o_done` and the next grant.
- SHAKE256 on requester 1 with obytes_len=1 → W=1; done after the first output word.
- Requester 1 changes `i_req_mode` and `i_req_obytes_len` mid-job and drops `i_req` → `o_core_mode` and lengths unchanged, and the job still completes with the original W.
- Assert `i_rstn`=0 mid S_BUSY, after 3 words → all outputs return to reset values at once; after release, a fresh request is granted from pointer 0.
- With `KECCAK_ARB_PRIO0_EN`: requesters 1 and 0 pending, 0 re-asserting after each done → requester 0 is always granted. Without the macro → grants alternate 0, 1.

Source files
------------

// File: rtl/keccak_arbiter_if.sv
// Requester/core stream bundle around the shared keccak sponge arbiter.
// slave = arbiter side; master = requesters plus core side.
interface keccak_arbiter_if #(
   parameter int N_REQ    = 4,
   parameter int BW_DATA  = 64,
   parameter int BW_IBLEN = 16,
   parameter int BW_OBLEN = 16
) ();
   logic [N_REQ-1:0]          i_req;
   logic [2*N_REQ-1:0]        i_req_mode;
   logic [BW_IBLEN*N_REQ-1:0] i_req_ibytes_len;
   logic [BW_OBLEN*N_REQ-1:0] i_req_obytes_len;
   logic [BW_DATA*N_REQ-1:0]  i_req_ibytes;
   logic [N_REQ-1:0]          i_req_ibytes_valid;
   logic [N_REQ-1:0]          o_req_ibytes_ready;
   logic [BW_DATA-1:0]        o_req_obytes;
   logic [N_REQ-1:0]          o_req_obytes_valid;
   logic [N_REQ-1:0]          o_gnt;
   logic [N_REQ-1:0]          o_done;
   logic [1:0]                o_core_mode;
   logic [BW_IBLEN-1:0]       o_core_ibytes_len;
   logic [BW_OBLEN-1:0]       o_core_obytes_len;
   logic [BW_DATA-1:0]        o_core_ibytes;
   logic                      o_core_ibytes_valid;
   logic                      i_core_ibytes_ready;
   logic [BW_DATA-1:0]        i_core_obytes;
   logic                      i_core_obytes_valid;

   modport slave (
      input  i_req, i_req_mode, i_req_ibytes_len, i_req_obytes_len,
             i_req_ibytes, i_req_ibytes_valid,
             i_core_ibytes_ready, i_core_obytes, i_core_obytes_valid,
      output o_req_ibytes_ready, o_req_obytes, o_req_obytes_valid,
             o_gnt, o_done, o_core_mode, o_core_ibytes_len, o_core_obytes_len,
             o_core_ibytes, o_core_ibytes_valid
   );

   modport master (
      output i_req, i_req_mode, i_req_ibytes_len, i_req_obytes_len,
             i_req_ibytes, i_req_ibytes_valid,
             i_core_ibytes_ready, i_core_obytes, i_core_obytes_valid,
      input  o_req_ibytes_ready, o_req_obytes, o_req_obytes_valid,
             o_gnt, o_done, o_core_mode, o_core_ibytes_len, o_core_obytes_len,
             o_core_ibytes, o_core_ibytes_valid
   );
endinterface

// File: rtl/keccak_arbiter.sv
// Round-robin job arbiter locking the shared keccak core to one requester per job.
// Define KECCAK_ARB_PRIO0_EN to give requester 0 absolute priority over round-robin.
module keccak_arbiter #(
   parameter int N_REQ    = 4,
   parameter int BW_DATA  = 64,
   parameter int BW_IBLEN = 16,
   parameter int BW_OBLEN = 16
) (
   input logic             i_clk,
   input logic             i_rstn,
   keccak_arbiter_if.slave bus
);
   localparam int IDX_W   = $clog2(N_REQ);
   localparam int WBYTES  = BW_DATA / 8;
   localparam int CNT_W   = BW_OBLEN + 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t state, state_nxt;

   logic [IDX_W-1:0]    ptr, ptr_nxt, win, gnt_idx;
   logic                win_vld, last_word;
   logic [N_REQ-1:0]    gnt;
   logic [1:0]          core_mode;
   logic [BW_IBLEN-1:0] core_ilen;
   logic [BW_OBLEN-1:0] core_olen;
   logic [CNT_W-1:0]    cnt, words;

   logic [1:0]          mode_a [N_REQ];
   logic [BW_IBLEN-1:0] ilen_a [N_REQ];
   logic [BW_OBLEN-1:0] olen_a [N_REQ];
   logic [BW_DATA-1:0]  idat_a [N_REQ];

   // SHA3 digests have fixed sizes; SHAKE uses the requested length, never fewer than one word.
   function automatic logic [CNT_W-1:0] calc_words(input logic [1:0] mode,
                                                   input logic [BW_OBLEN-1:0] olen);
      logic [CNT_W-1:0] nbytes;
      logic [CNT_W-1:0] w;
      case (mode)
         2'd2:    nbytes = CNT_W'(32);
         2'd3:    nbytes = CNT_W'(64);
         default: nbytes = {1'b0, olen};
      endcase
      w = (nbytes + CNT_W'(WBYTES - 1)) / CNT_W'(WBYTES);
      if (w == '0) w = CNT_W'(1);
      return w;
   endfunction

   always_comb begin : unpack
      for (int i = 0; i < N_REQ; i++) begin
         mode_a[i] = bus.i_req_mode[i*2 +: 2];
         ilen_a[i] = bus.i_req_ibytes_len[i*BW_IBLEN +: BW_IBLEN];
         olen_a[i] = bus.i_req_obytes_len[i*BW_OBLEN +: BW_OBLEN];
         idat_a[i] = bus.i_req_ibytes[i*BW_DATA +: BW_DATA];
      end
   end

   always_comb begin : rr_search
      int               j;
      logic [IDX_W-1:0] jj;
      win     = '0;
      win_vld = 1'b0;
      j       = 0;
      jj      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         jj = IDX_W'(j);
         if (!win_vld && bus.i_req[jj]) begin
            win     = jj;
            win_vld = 1'b1;
         end
      end
`ifdef KECCAK_ARB_PRIO0_EN
      if (bus.i_req[0]) begin
         win     = '0;
         win_vld = 1'b1;
      end
`endif
   end

   assign ptr_nxt   = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
   assign last_word = bus.i_core_obytes_valid && (cnt == words - 1'b1);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (win_vld)   state_nxt = S_BUSY;
         S_BUSY:  if (last_word) state_nxt = S_DONE;
         S_DONE:                 state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // Job context is captured only on the grant edge so requesters may change their inputs freely.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         ptr       <= '0;
         gnt_idx   <= '0;
         gnt       <= '0;
         core_mode <= '0;
         core_ilen <= '0;
         core_olen <= '0;
         words     <= CNT_W'(1);
         cnt       <= '0;
      end else begin
         case (state)
            S_IDLE: if (win_vld) begin
               gnt_idx   <= win;
               gnt       <= N_REQ'(1) << win;
               core_mode <= mode_a[win];
               core_ilen <= ilen_a[win];
               core_olen <= olen_a[win];
               words     <= calc_words(mode_a[win], olen_a[win]);
`ifdef KECCAK_ARB_PRIO0_EN
               if (win != '0) ptr <= ptr_nxt;
`else
               ptr <= ptr_nxt;
`endif
            end
            S_BUSY: if (bus.i_core_obytes_valid) cnt <= cnt + 1'b1;
            S_DONE: begin
               cnt <= '0;
               gnt <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.o_req_ibytes_ready  = '0;
      bus.o_req_obytes_valid  = '0;
      bus.o_req_obytes        = '0;
      bus.o_core_ibytes       = '0;
      bus.o_core_ibytes_valid = 1'b0;
      bus.o_done              = '0;
      if (state == S_BUSY) begin
         bus.o_req_ibytes_ready[gnt_idx] = bus.i_core_ibytes_ready;
         bus.o_req_obytes_valid[gnt_idx] = bus.i_core_obytes_valid;
         bus.o_req_obytes                = bus.i_core_obytes;
         bus.o_core_ibytes               = idat_a[gnt_idx];
         bus.o_core_ibytes_valid         = bus.i_req_ibytes_valid[gnt_idx];
      end
      if (state == S_DONE) bus.o_done = gnt;
   end

   assign bus.o_gnt             = gnt;
   assign bus.o_core_mode       = core_mode;
   assign bus.o_core_ibytes_len = core_ilen;
   assign bus.o_core_obytes_len = core_olen;
endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter: grant order, word counts, job locking, reset, priority option.
module tb_keccak_arbiter;
   localparam int N_REQ    = 4;
   localparam int BW_DATA  = 64;
   localparam int BW_IBLEN = 16;
   localparam int BW_OBLEN = 16;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_err = 0;
   int   n_chk = 0;
   int   nw;
   bit   gd;
   int   order [3] = '{0, 1, 3};
   int   exp_g;

   always #5 clk = ~clk;

   keccak_arbiter_if #(.N_REQ(N_REQ), .BW_DATA(BW_DATA), .BW_IBLEN(BW_IBLEN), .BW_OBLEN(BW_OBLEN)) bus ();

   keccak_arbiter #(.N_REQ(N_REQ), .BW_DATA(BW_DATA), .BW_IBLEN(BW_IBLEN), .BW_OBLEN(BW_OBLEN)) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int g, input logic [1:0] mode, input int ilen, input int olen);
      bus.i_req_mode[g*2 +: 2]                     = mode;
      bus.i_req_ibytes_len[g*BW_IBLEN +: BW_IBLEN] = BW_IBLEN'(ilen);
      bus.i_req_obytes_len[g*BW_OBLEN +: BW_OBLEN] = BW_OBLEN'(olen);
   endtask

   // Feed core output words until the granted requester sees its done pulse (bounded).
   task automatic serve(input int g, output int nwords, output bit got_done);
      nwords   = 0;
      got_done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.o_done[g]) begin
            got_done = 1'b1;
            break;
         end
         bus.i_core_obytes_valid = 1'b1;
         bus.i_core_obytes       = 64'hA5A5_0000_0000_0000 + 64'(c);
         #1;
         if (bus.o_req_obytes_valid[g]) nwords++;
      end
      bus.i_core_obytes_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_req               = '0;
      bus.i_req_mode          = '0;
      bus.i_req_ibytes_len    = '0;
      bus.i_req_obytes_len    = '0;
      bus.i_req_ibytes        = '0;
      bus.i_req_ibytes_valid  = '0;
      bus.i_core_ibytes_ready = 1'b0;
      bus.i_core_obytes       = '0;
      bus.i_core_obytes_valid = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Reset values
      chk("rst_gnt",        64'(bus.o_gnt), 64'h0);
      chk("rst_done",       64'(bus.o_done), 64'h0);
      chk("rst_mode",       64'(bus.o_core_mode), 64'h0);
      chk("rst_ilen",       64'(bus.o_core_ibytes_len), 64'h0);
      chk("rst_olen",       64'(bus.o_core_obytes_len), 64'h0);
      chk("rst_core_ivld",  64'(bus.o_core_ibytes_valid), 64'h0);
      chk("rst_req_irdy",   64'(bus.o_req_ibytes_ready), 64'h0);
      chk("rst_req_ovld",   64'(bus.o_req_obytes_valid), 64'h0);

      // Core output while idle is dropped
      bus.i_core_obytes_valid = 1'b1;
      bus.i_core_obytes       = 64'h1111_2222_3333_4444;
      #1;
      chk("idle_drop_vld",  64'(bus.o_req_obytes_valid), 64'h0);
      chk("idle_drop_data", bus.o_req_obytes, 64'h0);
      @(negedge clk);
      bus.i_core_obytes_valid = 1'b0;

      // Requesters 0,1,3 together, SHAKE128 168 bytes -> 21 words each, order 0,1,3
      set_req(0, 2'd0, 0, 168);
      set_req(1, 2'd0, 0, 168);
      set_req(3, 2'd0, 0, 168);
      bus.i_req = 4'b1011;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rr_gnt%0d", i), 64'(bus.o_gnt), 64'(4'b0001 << order[i]));
         chk($sformatf("rr_olen%0d", i), 64'(bus.o_core_obytes_len), 64'd168);
         serve(order[i], nw, gd);
         chk($sformatf("rr_words%0d", i), 64'(nw), 64'd21);
         chk($sformatf("rr_donef%0d", i), 64'(gd), 64'd1);
         chk($sformatf("rr_done%0d", i), 64'(bus.o_done), 64'(4'b0001 << order[i]));
         bus.i_req[order[i]] = 1'b0;
         @(negedge clk);
         chk($sformatf("rr_idle_gnt%0d", i), 64'(bus.o_gnt), 64'h0);
         chk($sformatf("rr_idle_done%0d", i), 64'(bus.o_done), 64'h0);
         if (i < 2) @(negedge clk);
      end

      // Requester 2 SHA3_512, 32 input bytes -> 8 output words
      set_req(2, 2'd3, 32, 0);
      bus.i_req[2] = 1'b1;
      @(negedge clk);
      chk("s512_gnt",  64'(bus.o_gnt), 64'h4);
      chk("s512_mode", 64'(bus.o_core_mode), 64'd3);
      chk("s512_ilen", 64'(bus.o_core_ibytes_len), 64'd32);
      bus.i_req_ibytes[2*BW_DATA +: BW_DATA] = 64'h0123_4567_89AB_CDEF;
      bus.i_req_ibytes[1*BW_DATA +: BW_DATA] = 64'hFFFF_0000_FFFF_0000;
      bus.i_req_ibytes_valid  = 4'b0110;
      bus.i_core_ibytes_ready = 1'b1;
      #1;
      chk("s512_core_idat", bus.o_core_ibytes, 64'h0123_4567_89AB_CDEF);
      chk("s512_core_ivld", 64'(bus.o_core_ibytes_valid), 64'd1);
      chk("s512_req_irdy",  64'(bus.o_req_ibytes_ready), 64'h4);
      bus.i_req_ibytes_valid = 4'b0010;
      #1;
      chk("s512_other_ivld", 64'(bus.o_core_ibytes_valid), 64'd0);
      bus.i_req_ibytes_valid  = '0;
      bus.i_core_ibytes_ready = 1'b0;
      serve(2, nw, gd);
      chk("s512_words", 64'(nw), 64'd8);
      chk("s512_done",  64'(bus.o_done), 64'h4);
      bus.i_req = '0;
      @(negedge clk);
      chk("s512_done_clr", 64'(bus.o_done), 64'h0);
      chk("s512_gnt_clr",  64'(bus.o_gnt), 64'h0);

      // Requester 1 SHAKE256, 1 output byte -> single word
      set_req(1, 2'd1, 0, 1);
      bus.i_req = 4'b0010;
      @(negedge clk);
      chk("w1_gnt",  64'(bus.o_gnt), 64'h2);
      chk("w1_mode", 64'(bus.o_core_mode), 64'd1);
      bus.i_core_obytes_valid = 1'b1;
      bus.i_core_obytes       = 64'hDEAD_BEEF_0000_0001;
      #1;
      chk("w1_odata", bus.o_req_obytes, 64'hDEAD_BEEF_0000_0001);
      chk("w1_ovld",  64'(bus.o_req_obytes_valid), 64'h2);
      @(negedge clk);
      bus.i_core_obytes_valid = 1'b0;
      chk("w1_done", 64'(bus.o_done), 64'h2);
      bus.i_req = '0;
      @(negedge clk);
      chk("w1_gnt_clr", 64'(bus.o_gnt), 64'h0);

      // Requester 1 changes its inputs and drops request mid-job
      set_req(1, 2'd0, 16, 40);
      bus.i_req = 4'b0010;
      @(negedge clk);
      chk("lock_gnt", 64'(bus.o_gnt), 64'h2);
      set_req(1, 2'd3, 99, 8);
      bus.i_req = '0;
      #1;
      chk("lock_mode", 64'(bus.o_core_mode), 64'd0);
      chk("lock_ilen", 64'(bus.o_core_ibytes_len), 64'd16);
      chk("lock_olen", 64'(bus.o_core_obytes_len), 64'd40);
      serve(1, nw, gd);
      chk("lock_words", 64'(nw), 64'd5);
      chk("lock_done",  64'(bus.o_done), 64'h2);
      @(negedge clk);

      // Asynchronous reset after 3 words of a job on requester 2
      set_req(2, 2'd0, 0, 168);
      bus.i_req = 4'b0100;
      @(negedge clk);
      chk("ar_gnt", 64'(bus.o_gnt), 64'h4);
      bus.i_req_ibytes_valid  = 4'b0100;
      bus.i_core_ibytes_ready = 1'b1;
      bus.i_core_obytes       = 64'h5555_AAAA_5555_AAAA;
      repeat (3) begin
         bus.i_core_obytes_valid = 1'b1;
         @(negedge clk);
      end
      rstn = 1'b0;
      #1;
      chk("ar_gnt0",   64'(bus.o_gnt), 64'h0);
      chk("ar_done0",  64'(bus.o_done), 64'h0);
      chk("ar_olen0",  64'(bus.o_core_obytes_len), 64'h0);
      chk("ar_ivld0",  64'(bus.o_core_ibytes_valid), 64'h0);
      chk("ar_irdy0",  64'(bus.o_req_ibytes_ready), 64'h0);
      chk("ar_ovld0",  64'(bus.o_req_obytes_valid), 64'h0);
      chk("ar_odata0", bus.o_req_obytes, 64'h0);
      bus.i_core_obytes_valid = 1'b0;
      bus.i_req_ibytes_valid  = '0;
      bus.i_core_ibytes_ready = 1'b0;
      bus.i_req               = '0;
      @(negedge clk);
      rstn = 1'b1;
      set_req(1, 2'd0, 0, 8);
      set_req(3, 2'd0, 0, 8);
      bus.i_req = 4'b1010;
      @(negedge clk);
      chk("ar_ptr0_gnt", 64'(bus.o_gnt), 64'h2);
      serve(1, nw, gd);
      chk("ar_words1", 64'(nw), 64'd1);
      bus.i_req[1] = 1'b0;
      @(negedge clk);
      chk("ar_turn_gnt", 64'(bus.o_gnt), 64'h0);
      @(negedge clk);
      chk("ar_gnt3", 64'(bus.o_gnt), 64'h8);
      serve(3, nw, gd);
      chk("ar_words3", 64'(nw), 64'd1);
      bus.i_req = '0;
      @(negedge clk);

      // Requesters 0 and 1 pending; each re-asserts after its done
      set_req(0, 2'd0, 0, 8);
      set_req(1, 2'd0, 0, 8);
      bus.i_req = 4'b0011;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
`ifdef KECCAK_ARB_PRIO0_EN
         exp_g = 0;
`else
         exp_g = k % 2;
`endif
         chk($sformatf("pri_gnt%0d", k), 64'(bus.o_gnt), 64'(4'b0001 << exp_g));
         serve(exp_g, nw, gd);
         chk($sformatf("pri_words%0d", k), 64'(nw), 64'd1);
         bus.i_req[exp_g] = 1'b0;
         if (k == 3) bus.i_req = '0;
         @(negedge clk);
         chk($sformatf("pri_idle%0d", k), 64'(bus.o_gnt), 64'h0);
         if (k < 3) begin
            bus.i_req[exp_g] = 1'b1;
            @(negedge clk);
         end
      end
      @(negedge clk);
      chk("end_gnt", 64'(bus.o_gnt), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
